rx_word_buf: RTL



---
 rtl/polar_pkg.sv | 13 +
 rtl/word_fifo_core.sv | 59 +++++
 rtl/rx_word_buf.sv | 71 +++++++
 3 files changed

// File: rtl/polar_pkg.sv
// Shared constants and helpers for the polar encode datapath.
package polar_pkg;

  localparam int unsigned WORD_W       = 128;
  localparam int unsigned RX_BUF_DEPTH = 4;
  localparam int unsigned DROP_CNT_W   = 8;

  // Pointer width needed to address a power-of-two number of slots.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/word_fifo_core.sv
// Word storage with wrapping pointers and a level counter; first-word-fall-through read.
// Callers decide when a write or read is legal; a simultaneous write+read while full overwrites the oldest word.
module word_fifo_core
  import polar_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W,
  parameter int unsigned DEPTH  = RX_BUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       rd_data,
  output logic [ptr_w(DEPTH):0]   level,
  output logic                    full,
  output logic                    valid
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_nxt;

  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({wr_en, rd_en})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      valid <= (level_nxt != '0);
    end
  end

endmodule

// File: rtl/rx_word_buf.sv
// Receive word buffer between the UART receiver and the polar encoder, with drop accounting.
// Optional RX_BUF_DROP_OLDEST_EN: on overflow overwrite the oldest word instead of dropping the newest.
module rx_word_buf
  import polar_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W,
  parameter int unsigned DEPTH  = RX_BUF_DEPTH,
  parameter int unsigned CNT_W  = DROP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_flag,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ptr_w(DEPTH):0] level,
  output logic                  full,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic [CNT_W-1:0]      drop_cnt
);

  logic pop;
  logic drop;
  logic wr_en;
  logic rd_en;

  assign pop  = out_valid & out_ready;
  assign drop = in_flag & full & ~pop;

`ifdef RX_BUF_DROP_OLDEST_EN
  // Overwrite: write and advance both pointers so the level stays at DEPTH.
  assign wr_en = in_flag;
  assign rd_en = pop | drop;
`else
  assign wr_en = in_flag & (~full | pop);
  assign rd_en = pop;
`endif

  word_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_data (out_data),
    .level   (level),
    .full    (full),
    .valid   (out_valid)
  );

  // A drop in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_clr)            drop_cnt <= CNT_W'(1);
      else if (~&drop_cnt)    drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
